jtag_tap_core: RTL and testbench

JTAG_TAP_CORE -- requirements
Module: jtag_tap_core

---
 rtl/jtag_tap_core.sv | 162 ++++++++++++++++
 tb/tb_jtag_tap_core.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_core.sv
// IEEE 1149.1 TAP controller with IR, IDCODE, BYPASS and one user data register.
// The user register exchanges a parallel word with the core on capture/update.
module jtag_tap_core #(
    parameter int          IR_WIDTH  = 4,
    parameter int          DR_WIDTH  = 8,
    parameter logic [31:0] IDCODE    = 32'h1234_5001,
    parameter int          IDCODE_OP = 1,
    parameter int          USER_OP   = 2
) (
    input  logic                TCLK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [3:0]          STATE,
    output logic [IR_WIDTH-1:0] IR,
    input  logic [DR_WIDTH-1:0] DR_IN,
    output logic [DR_WIDTH-1:0] DR_OUT,
    output logic                DR_UPD
);

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR_SCAN   = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT_1_DR        = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT_2_DR        = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR_SCAN   = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT_1_IR        = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT_2_IR        = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IDCODE_OPC = IDCODE_OP[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] USER_OPC   = USER_OP[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

    tap_state_t          state;
    tap_state_t          next_state;
    logic [IR_WIDTH-1:0] ir_reg;
    logic [IR_WIDTH-1:0] ir_shift;
    logic [31:0]         idcode_shift;
    logic [DR_WIDTH-1:0] user_shift;
    logic [DR_WIDTH:0]   user_ext;
    logic                bypass_reg;
    logic [DR_WIDTH-1:0] dr_out_reg;
    logic                dr_upd_reg;
    logic                sel_idcode;
    logic                sel_user;

    // IDCODE wins if both opcodes were ever configured identical.
    assign sel_idcode = (ir_reg == IDCODE_OPC);
    assign sel_user   = (ir_reg == USER_OPC) && !sel_idcode;
    assign user_ext   = {TDI, user_shift};

    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            state <= TEST_LOGIC_RESET;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            TEST_LOGIC_RESET: next_state = TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    next_state = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   next_state = TMS ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       next_state = TMS ? EXIT_1_DR        : SHIFT_DR;
            SHIFT_DR:         next_state = TMS ? EXIT_1_DR        : SHIFT_DR;
            EXIT_1_DR:        next_state = TMS ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         next_state = TMS ? EXIT_2_DR        : PAUSE_DR;
            EXIT_2_DR:        next_state = TMS ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        next_state = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   next_state = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       next_state = TMS ? EXIT_1_IR        : SHIFT_IR;
            SHIFT_IR:         next_state = TMS ? EXIT_1_IR        : SHIFT_IR;
            EXIT_1_IR:        next_state = TMS ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         next_state = TMS ? EXIT_2_IR        : PAUSE_IR;
            EXIT_2_IR:        next_state = TMS ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        next_state = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          next_state = TEST_LOGIC_RESET;
        endcase
    end

    // Pause/exit states fall through to default, so every shift register holds there.
    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            ir_reg       <= IDCODE_OPC;
            ir_shift     <= '0;
            idcode_shift <= '0;
            user_shift   <= '0;
            bypass_reg   <= 1'b0;
            dr_out_reg   <= '0;
            dr_upd_reg   <= 1'b0;
        end else begin
            dr_upd_reg <= 1'b0;
            case (state)
                TEST_LOGIC_RESET: ir_reg <= IDCODE_OPC;
                CAPTURE_IR:       ir_shift <= IR_CAPTURE;
                SHIFT_IR:         ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
                UPDATE_IR:        ir_reg <= ir_shift;
                CAPTURE_DR: begin
                    if (sel_idcode) begin
                        idcode_shift <= IDCODE;
                    end else if (sel_user) begin
                        user_shift <= DR_IN;
                    end else begin
                        bypass_reg <= 1'b0;
                    end
                end
                SHIFT_DR: begin
                    if (sel_idcode) begin
                        idcode_shift <= {TDI, idcode_shift[31:1]};
                    end else if (sel_user) begin
                        user_shift <= user_ext[DR_WIDTH:1];
                    end else begin
                        bypass_reg <= TDI;
                    end
                end
                UPDATE_DR: begin
                    if (sel_user) begin
                        dr_out_reg <= user_shift;
                        dr_upd_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (state == SHIFT_IR) begin
            TDO = ir_shift[0];
        end else if (state == SHIFT_DR) begin
            if (sel_idcode) begin
                TDO = idcode_shift[0];
            end else if (sel_user) begin
                TDO = user_shift[0];
            end else begin
                TDO = bypass_reg;
            end
        end
    end

    assign TDO_EN = (state == SHIFT_IR) || (state == SHIFT_DR);
    assign STATE  = state;
    assign IR     = ir_reg;
    assign DR_OUT = dr_out_reg;
    assign DR_UPD = dr_upd_reg;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Scoreboard bench for jtag_tap_core: stimulus queues expected TDO bits,
// a negedge monitor pops one per cycle while TDO_EN is high.
module tb_jtag_tap_core;

    logic       TCLK = 1'b0;
    logic       TRST;
    logic       TMS;
    logic       TDI;
    logic       TDO;
    logic       TDO_EN;
    logic [3:0] STATE;
    logic [3:0] IR;
    logic [7:0] DR_IN;
    logic [7:0] DR_OUT;
    logic       DR_UPD;

    int   checks = 0;
    int   errors = 0;
    logic expQ[$];

    jtag_tap_core dut (
        .TCLK   (TCLK),
        .TRST   (TRST),
        .TMS    (TMS),
        .TDI    (TDI),
        .TDO    (TDO),
        .TDO_EN (TDO_EN),
        .STATE  (STATE),
        .IR     (IR),
        .DR_IN  (DR_IN),
        .DR_OUT (DR_OUT),
        .DR_UPD (DR_UPD)
    );

    always #5 TCLK = ~TCLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One TCLK cycle; inputs change just after the rising edge.
    task automatic applyStimulus(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCLK);
        #1;
    endtask

    task automatic pushBits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) expQ.push_back(v[i]);
    endtask

    task automatic shiftBits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) applyStimulus(i == n - 1, v[i]);
    endtask

    // From run_test_idle, load a 4-bit opcode and return to run_test_idle.
    task automatic loadIr(input logic [3:0] op);
        pushBits(32'h1, 4);
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        shiftBits({28'h0, op}, 4);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
    endtask

    always @(negedge TCLK) begin
        if (TDO_EN === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL tdo_unexpected: got TDO %b with no expected bit queued", TDO);
            end else begin
                checkOutput("tdo_bit", {31'h0, TDO}, {31'h0, expQ.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        TRST  = 1'b0;
        TMS   = 1'b1;
        TDI   = 1'b0;
        DR_IN = 8'h00;

        #2 TRST = 1'b1;
        #1;
        checkOutput("rst_state", {28'h0, STATE}, 32'd0);
        checkOutput("rst_ir", {28'h0, IR}, 32'h1);
        checkOutput("rst_dr_out", {24'h0, DR_OUT}, 32'h0);
        checkOutput("rst_tdo_en", {31'h0, TDO_EN}, 32'h0);
        checkOutput("rst_dr_upd", {31'h0, DR_UPD}, 32'h0);
        @(posedge TCLK);
        #3 TRST = 1'b0;

        // IDCODE readout
        pushBits(32'h1234_5001, 32);
        applyStimulus(0, 0);
        checkOutput("tlr_to_rti", {28'h0, STATE}, 32'd1);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("enter_shift_dr", {28'h0, STATE}, 32'd4);
        shiftBits(32'hFFFF_FFFF, 32);
        checkOutput("idcode_all_bits", expQ.size(), 32'd0);
        checkOutput("exit1_dr", {28'h0, STATE}, 32'd5);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        checkOutput("idcode_no_upd", {24'h0, DR_OUT}, 32'h0);

        // IR load of all-ones selects BYPASS
        loadIr(4'hF);
        checkOutput("ir_bypass", {28'h0, IR}, 32'hF);
        checkOutput("ir_bits_done", expQ.size(), 32'd0);

        pushBits(32'b1010, 4);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        shiftBits(32'b1101, 4);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        checkOutput("bypass_bits_done", expQ.size(), 32'd0);
        checkOutput("bypass_dr_out", {24'h0, DR_OUT}, 32'h0);
        checkOutput("bypass_dr_upd", {31'h0, DR_UPD}, 32'h0);

        // USER write/read with a pause in the middle of the shift
        loadIr(4'h2);
        checkOutput("ir_user", {28'h0, IR}, 32'h2);
        DR_IN = 8'h3C;
        pushBits(32'h3C, 8);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        shiftBits(32'h5, 4);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("pause_dr", {28'h0, STATE}, 32'd6);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        checkOutput("resume_shift_dr", {28'h0, STATE}, 32'd4);
        shiftBits(32'hA, 4);
        checkOutput("user_bits_done", expQ.size(), 32'd0);
        checkOutput("user_pre_upd", {31'h0, DR_UPD}, 32'h0);
        applyStimulus(1, 0);
        checkOutput("update_dr", {28'h0, STATE}, 32'd8);
        checkOutput("user_dr_out_hold", {24'h0, DR_OUT}, 32'h0);
        applyStimulus(0, 0);
        checkOutput("user_dr_out", {24'h0, DR_OUT}, 32'hA5);
        checkOutput("user_dr_upd_hi", {31'h0, DR_UPD}, 32'h1);
        applyStimulus(0, 0);
        checkOutput("user_dr_upd_lo", {31'h0, DR_UPD}, 32'h0);

        // Soft reset from pause_IR
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        checkOutput("pause_ir", {28'h0, STATE}, 32'd13);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0);
        checkOutput("soft_rst_state", {28'h0, STATE}, 32'd0);
        checkOutput("soft_rst_ir", {28'h0, IR}, 32'h1);
        checkOutput("soft_rst_keeps_dr_out", {24'h0, DR_OUT}, 32'hA5);

        // TRST mid USER shift
        applyStimulus(0, 0);
        loadIr(4'h2);
        pushBits(32'h3C, 3);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        checkOutput("mid_shift_state", {28'h0, STATE}, 32'd4);
        #1 TRST = 1'b1;
        #1;
        checkOutput("trst_state", {28'h0, STATE}, 32'd0);
        checkOutput("trst_dr_out", {24'h0, DR_OUT}, 32'h0);
        checkOutput("trst_tdo_en", {31'h0, TDO_EN}, 32'h0);
        checkOutput("trst_ir", {28'h0, IR}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge TCLK);
            checkOutput("trst_no_dr_upd", {31'h0, DR_UPD}, 32'h0);
        end
        #1 TRST = 1'b0;
        applyStimulus(0, 0);
        checkOutput("post_trst_rti", {28'h0, STATE}, 32'd1);
        checkOutput("post_trst_dr_upd", {31'h0, DR_UPD}, 32'h0);
        checkOutput("final_queue_empty", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
